mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one synchronous data-memory port between NUM_PORTS requesters.
//  Port 0 is the core datapath (stage four/five load/store); the other ports are
//  debug/LCD readers. Each transaction is one word and is either a read or a write.
//  The block sits between the requesters and the data memory, in place of a direct wire.
//  Provides fixed-priority or round-robin arbitration and a per-port read-response strobe.
// PARAMETERS
//  NUM_PORTS     2    number of requesters (2..8)
//  ADDR_WIDTH    32   address width
//  DATA_WIDTH    32   data width
//  READ_LATENCY  1    cycles from mem_read high until mem_rdata is valid (1..4)
//  RR_MODE       1    1 = round-robin; 0 = fixed priority (lowest index wins)
// PORTS
//  clk        in   1                     clock, rising edge
//  rst        in   1                     synchronous reset, active low
//  req        in   NUM_PORTS             per-port request, held until gnt
//  we         in   NUM_PORTS             per-port 1 = write, 0 = read; valid with req
//  addr       in   NUM_PORTS*ADDR_WIDTH  per-port address; port i = bits [i*AW +: AW]
//  wdata      in   NUM_PORTS*DATA_WIDTH  per-port write data; same packing as addr
//  gnt        out  NUM_PORTS             one-hot, 1-cycle pulse: request accepted
//  rvalid     out  NUM_PORTS             one-hot, 1-cycle pulse: rdata is valid for that port
//  rdata      out  DATA_WIDTH            read data, shared by all ports
//  busy       out  1                     high in every state except IDLE
//  mem_addr   out  ADDR_WIDTH            memory address, registered
//  mem_wdata  out  DATA_WIDTH            memory write data, registered
//  mem_read   out  1                     memory read enable, 1-cycle pulse
//  mem_write  out  1                     memory write enable, 1-cycle pulse
//  mem_rdata  in   DATA_WIDTH            memory read data
// BEHAVIOUR
//  - Reset (rst = 0 at a rising edge): state = IDLE; all outputs = 0; rr pointer = 0.
//    Reset applied mid-transaction abandons the transaction; no rvalid is produced.
//  - States: IDLE, ISSUE, WAIT, RESP.
//  - IDLE: when any req is high, select winner w and register addr/wdata/we of w
//    into mem_addr, mem_wdata and the op; go to ISSUE. If no req is high, stay in IDLE.
//  - ISSUE (1 cycle): gnt[w] = 1. mem_read = ~we_w and mem_write = we_w.
//    A write goes to IDLE. A read goes to WAIT with cnt = READ_LATENCY-1.
//  - WAIT: lasts READ_LATENCY cycles. On its last cycle, capture mem_rdata into rdata
//    and go to RESP.
//  - RESP (1 cycle): rvalid[w] = 1; then go to IDLE. rdata holds its value until the next
//    read capture.
//  - Timing: a request seen in IDLE at edge E gives gnt during cycle E+1. A read issued
//    in cycle T gives rvalid in cycle T+READ_LATENCY+1.
//  - Throughput: a write takes 2 cycles; a read takes READ_LATENCY+3 cycles.
//    Arbitration happens only in IDLE.
//  - Fixed priority: w = lowest index with req high.
//  - Round-robin: search starts at ptr and wraps modulo NUM_PORTS.
//    On each grant, ptr = w+1, wrapping from NUM_PORTS-1 to 0.
//  - The requester keeps req/we/addr/wdata stable until it sees gnt, and deasserts req
//    in the cycle after gnt unless it issues a new request.
//  - A req that drops before gnt is a protocol violation; behaviour is undefined.
//  - mem_addr and mem_wdata hold their last value outside ISSUE.
//    Exactly one of mem_read/mem_write is high, and only in ISSUE.
//  - gnt, rvalid, mem_read and mem_write are never high for more than 1 cycle per
//    transaction.
// TESTING
//  - Reset: hold rst=0 for 3 cycles with all req high -> gnt, rvalid, mem_read,
//    mem_write and busy all stay 0.
//  - Single read, RL=1: port1 reads addr 0x10 and memory returns 0xCAFE0001 ->
//    gnt[1] at T; mem_read at T with mem_addr=0x10; rvalid[1] at T+2 with
//    rdata=0xCAFE0001.
//  - Write: port0 writes 0x1234 to 0x20 -> gnt[0] and mem_write in the same cycle with
//    mem_addr=0x20 and mem_wdata=0x1234; no rvalid; busy drops the next cycle.
//  - Contention, RR_MODE=1, NUM_PORTS=3: all ports hold read requests ->
//    grant order 0,1,2,0. RR_MODE=0 with the same stimulus -> port 0 is granted
//    every time.
//  - Latency sweep: READ_LATENCY = 1..4 -> rvalid arrives exactly RL+1 cycles after
//    mem_read, and rdata matches the memory model.
//  - Reset mid-read: drop rst in WAIT -> no rvalid; the next request is serviced
//    normally and the rr pointer restarts at 0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbiter that shares one synchronous data-memory port between NUM_PORTS
// requesters. Port 0 is the core load/store path; the others are debug/LCD
// readers. One single-word read or write is in flight at a time. The winner is
// chosen in IDLE by fixed priority or round-robin, issued for one cycle, and a
// read's data comes back on the shared rdata bus with a per-port rvalid strobe.
module mem_port_arbiter #(
    parameter int NUM_PORTS    = 2,
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int READ_LATENCY = 1,
    parameter int RR_MODE      = 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_PORTS-1:0]             req,
    input  logic [NUM_PORTS-1:0]             we,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  addr,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]  wdata,
    output logic [NUM_PORTS-1:0]             gnt,
    output logic [NUM_PORTS-1:0]             rvalid,
    output logic [DATA_WIDTH-1:0]            rdata,
    output logic                             busy,
    output logic [ADDR_WIDTH-1:0]            mem_addr,
    output logic [DATA_WIDTH-1:0]            mem_wdata,
    output logic                             mem_read,
    output logic                             mem_write,
    input  logic [DATA_WIDTH-1:0]            mem_rdata
);

    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int CW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [PW-1:0] ptr;       // round-robin search start
    logic [PW-1:0] win;       // port owning the transaction in flight
    logic [PW-1:0] win_c;     // port that would win if arbitration happened now
    logic          found;
    logic          op_we;     // latched operation of the winner
    logic [CW-1:0] cnt;       // remaining WAIT cycles minus one

    // Pick the first requesting port, searching upward from ptr (round-robin)
    // or from port 0 (fixed priority), wrapping modulo NUM_PORTS.
    always_comb begin : pick_winner
        int start;
        int idx;
        // NOTE: every variable written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        win_c = '0;
        found = 1'b0;
        start = (RR_MODE != 0) ? int'(ptr) : 0;
        idx   = 0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            idx = (start + i) % NUM_PORTS;
            if (!found && req[idx]) begin
                found = 1'b1;
                win_c = PW'(idx);
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (found) state_nxt = ISSUE;
            ISSUE:   state_nxt = op_we ? IDLE : WAIT;
            WAIT:    if (cnt == '0) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Strobes decoded from state; each is high for exactly one cycle.
    always_comb begin
        gnt       = '0;
        rvalid    = '0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        busy      = (state != IDLE);
        case (state)
            ISSUE: begin
                gnt[win]  = 1'b1;
                mem_read  = ~op_we;
                mem_write = op_we;
            end
            RESP:    rvalid[win] = 1'b1;
            default: ;
        endcase
    end

    // Datapath: latch the winner's request in IDLE, count read latency in
    // WAIT and capture the memory's read data on the last WAIT cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr       <= '0;
            win       <= '0;
            op_we     <= 1'b0;
            cnt       <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rdata     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        win       <= win_c;
                        op_we     <= we[win_c];
                        mem_addr  <= addr[win_c*ADDR_WIDTH +: ADDR_WIDTH];
                        mem_wdata <= wdata[win_c*DATA_WIDTH +: DATA_WIDTH];
                        if (RR_MODE != 0) begin
                            ptr <= (win_c == PW'(NUM_PORTS - 1)) ? '0 : win_c + 1'b1;
                        end
                    end
                end
                ISSUE: cnt <= CW'(READ_LATENCY - 1);
                WAIT: begin
                    if (cnt == '0) begin
                        rdata <= mem_rdata;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
